ddr3_line_responder: RTL and testbench

- Responder end of the 256-bit line port (ctrl_addr_i/ctrl_data_i/ctrl_data_o/ctrl_we_i/ctrl_rd_i/ctrl_ack_o) driven by the DDR3 line cache.
- Each line request becomes 8 sequential 32-bit word transfers on a narrow word-memory bus (on-chip RAM, SRAM bridge or simulation model).
- Used wherever the cache runs against a 32-bit backing store instead of the wide DDR3 controller.

---
 rtl/ddr3_line_responder_pkg.sv | 34 +++
 rtl/ddr3_line_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_ddr3_line_responder.sv | 546 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_line_responder_pkg.sv
// ddr3_line_responder_pkg
//   Shared constants and state encoding for the 256-bit line responder.
//   Contents:
//     get_width()        bits needed to index n items (minimum 1)
//     LINE_BITS          width of one cache line (256)
//     WORD_BITS          width of one backing-store word (32)
//     WORDS_PER_LINE     beats per line transfer (8)
//     BEAT_BITS          beat counter width (3)
//     LINE_OFFSET_BITS   byte-offset bits inside a line (5)
//     WORD_OFFSET_BITS   byte-offset bits inside a word (2)
//     state_e            S_IDLE=0, S_WRITE=1, S_READ=2, S_ACK=3
package ddr3_line_responder_pkg;

    function automatic int get_width(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return w;
    endfunction

    localparam int LINE_BITS        = 256;
    localparam int WORD_BITS        = 32;
    localparam int WORDS_PER_LINE   = LINE_BITS / WORD_BITS;
    localparam int BEAT_BITS        = get_width(WORDS_PER_LINE);
    localparam int LINE_OFFSET_BITS = get_width(LINE_BITS / 8);
    localparam int WORD_OFFSET_BITS = get_width(WORD_BITS / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/ddr3_line_responder.sv
// ddr3_line_responder
//   Serves 256-bit line requests from the DDR3 line cache by issuing eight
//   sequential 32-bit word transfers on a narrow word-memory bus.
//
//   Handshakes:
//     ctrl side : ctrl_we_i / ctrl_rd_i are levels held by the requester until
//                 ctrl_ack_o, a single-cycle pulse. Levels are only looked at in
//                 S_IDLE, so a request raised on the ack edge is taken on the
//                 cycle after the ack.
//     mem side  : mem_we_o / mem_rd_o are held (with stable address/data) until
//                 a cycle where mem_ack_i is high; every such cycle completes one
//                 beat and the next beat is presented immediately after.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     ctrl_addr_i         line byte address (bits [4:0] ignored)
//     ctrl_data_i         write line, word k at [32k+31:32k]
//     ctrl_data_o         read line buffer, same mapping
//     ctrl_we_i/rd_i      line write / read request levels
//     ctrl_ack_o          line completion pulse
//     mem_addr_o          word byte address
//     mem_data_o          write word
//     mem_data_i          read word, valid with mem_ack_i
//     mem_we_o/rd_o       word write / read request
//     mem_ack_i           beat completion
//     err_o               sticky error (simultaneous we+rd, or watchdog)
//     state_value         FSM state, zero-extended, for debug
//
//   Optional build macro: DDR3_LINE_TIMEOUT_EN adds a per-beat watchdog of
//   TIMEOUT_CYCLES that abandons the line, flags err_o and still acks.
module ddr3_line_responder
    import ddr3_line_responder_pkg::*;
#(
    parameter int ADDR_BITS      = 29,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_BITS-1:0]   ctrl_addr_i,
    input  logic [LINE_BITS-1:0]   ctrl_data_i,
    output logic [LINE_BITS-1:0]   ctrl_data_o,
    input  logic                   ctrl_we_i,
    input  logic                   ctrl_rd_i,
    output logic                   ctrl_ack_o,
    output logic [ADDR_BITS-1:0]   mem_addr_o,
    output logic [WORD_BITS-1:0]   mem_data_o,
    input  logic [WORD_BITS-1:0]   mem_data_i,
    output logic                   mem_we_o,
    output logic                   mem_rd_o,
    input  logic                   mem_ack_i,
    output logic                   err_o,
    output logic [15:0]            state_value
);

    localparam int LINE_ADDR_BITS = ADDR_BITS - LINE_OFFSET_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS_PER_LINE - 1);

    state_e                    state_q, state_d;
    logic [BEAT_BITS-1:0]      beat_q, beat_d;
    logic [LINE_ADDR_BITS-1:0] line_q, line_d;
    logic [LINE_BITS-1:0]      wbuf_q, wbuf_d;
    logic [LINE_BITS-1:0]      rbuf_q, rbuf_d;
    logic                      err_q, err_d;

    logic                      mem_active;
    logic                      timed_out;
    logic [WORD_BITS-1:0]      wr_word;

    // Line offset bits are discarded by design; the line base is all we keep.
    logic                      unused_addr_bits;
    assign unused_addr_bits = ^ctrl_addr_i[LINE_OFFSET_BITS-1:0];

    assign mem_active = (state_q == S_WRITE) || (state_q == S_READ);

`ifdef DDR3_LINE_TIMEOUT_EN
    localparam int TO_BITS = get_width(TIMEOUT_CYCLES + 1);
    localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT_CYCLES);

    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;

    // Counts cycles the current beat has been pending; a completed beat or a
    // fresh line restarts it, so the limit applies to each beat separately.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_IDLE) begin
            to_cnt_d = '0;
        end else if (mem_active) begin
            if (mem_ack_i || timed_out) begin
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // An ack arriving in the limit cycle still completes the beat normally.
    assign timed_out = mem_active && !mem_ack_i && (to_cnt_q == TO_LIMIT);
`else
    // No watchdog: a beat waits for mem_ack_i forever.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state logic. Request levels matter only in S_IDLE.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_we_i) begin
                    // Write wins a simultaneous request; the read is dropped
                    // and flagged so the requester sees exactly one ack.
                    wbuf_d  = ctrl_data_i;
                    line_d  = ctrl_addr_i[ADDR_BITS-1:LINE_OFFSET_BITS];
                    beat_d  = '0;
                    state_d = S_WRITE;
                    if (ctrl_rd_i) begin
                        err_d = 1'b1;
                    end
                end else if (ctrl_rd_i) begin
                    line_d  = ctrl_addr_i[ADDR_BITS-1:LINE_OFFSET_BITS];
                    beat_d  = '0;
                    state_d = S_READ;
                end
            end

            S_WRITE, S_READ: begin
                if (timed_out) begin
                    // Abandon the line; unread words keep their old contents.
                    beat_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else if (mem_ack_i) begin
                    if (state_q == S_READ) begin
                        case (beat_q)
                            3'd0: rbuf_d[31:0]    = mem_data_i;
                            3'd1: rbuf_d[63:32]   = mem_data_i;
                            3'd2: rbuf_d[95:64]   = mem_data_i;
                            3'd3: rbuf_d[127:96]  = mem_data_i;
                            3'd4: rbuf_d[159:128] = mem_data_i;
                            3'd5: rbuf_d[191:160] = mem_data_i;
                            3'd6: rbuf_d[223:192] = mem_data_i;
                            3'd7: rbuf_d[255:224] = mem_data_i;
                            default: rbuf_d = rbuf_q;
                        endcase
                    end
                    // Wraps to 0 after the last beat, ready for the next line.
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_ACK;
                    end
                end
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            err_q   <= err_d;
        end
    end

    // Write word select for the current beat.
    always_comb begin
        wr_word = '0;
        case (beat_q)
            3'd0: wr_word = wbuf_q[31:0];
            3'd1: wr_word = wbuf_q[63:32];
            3'd2: wr_word = wbuf_q[95:64];
            3'd3: wr_word = wbuf_q[127:96];
            3'd4: wr_word = wbuf_q[159:128];
            3'd5: wr_word = wbuf_q[191:160];
            3'd6: wr_word = wbuf_q[223:192];
            3'd7: wr_word = wbuf_q[255:224];
            default: wr_word = '0;
        endcase
    end

    // The beat index fills the offset bits directly, so the word address can
    // never carry into the line base.
    assign mem_addr_o  = mem_active ? {line_q, beat_q, {WORD_OFFSET_BITS{1'b0}}} : '0;
    assign mem_data_o  = (state_q == S_WRITE) ? wr_word : '0;
    assign mem_we_o    = (state_q == S_WRITE) && !timed_out;
    assign mem_rd_o    = (state_q == S_READ) && !timed_out;
    assign ctrl_ack_o  = (state_q == S_ACK);
    assign ctrl_data_o = rbuf_q;
    assign err_o       = err_q;
    assign state_value = {14'd0, state_q};

endmodule

// File: tb/tb_ddr3_line_responder.sv
module tb_ddr3_line_responder;

  localparam int AW = 29;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [AW-1:0]    ctrl_addr_i;
  logic [255:0]     ctrl_data_i;
  logic [255:0]     ctrl_data_o;
  logic             ctrl_we_i;
  logic             ctrl_rd_i;
  logic             ctrl_ack_o;
  logic [AW-1:0]    mem_addr_o;
  logic [31:0]      mem_data_o;
  logic [31:0]      mem_data_i;
  logic             mem_we_o;
  logic             mem_rd_o;
  logic             mem_ack_i;
  logic             err_o;
  logic [15:0]      state_value;

  ddr3_line_responder #(
    .ADDR_BITS      (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl_addr_i (ctrl_addr_i),
    .ctrl_data_i (ctrl_data_i),
    .ctrl_data_o (ctrl_data_o),
    .ctrl_we_i   (ctrl_we_i),
    .ctrl_rd_i   (ctrl_rd_i),
    .ctrl_ack_o  (ctrl_ack_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_we_o    (mem_we_o),
    .mem_rd_o    (mem_rd_o),
    .mem_ack_i   (mem_ack_i),
    .err_o       (err_o),
    .state_value (state_value)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory model controls: 0 = ack tied high, 1 = random 0-5 cycle delay, 2 = ack stuck low
  int          ack_mode = 0;
  logic [31:0] rd_base  = 32'h0;
  int          dly      = 0;
  bit          armed    = 1'b0;

  // scoreboard of observed beats
  logic [AW-1:0] obs_addr_q[$];
  logic [31:0]   obs_data_q[$];
  logic          obs_we_q[$];
  int            ack_cnt      = 0;
  int            last_ack_cyc = 0;
  int            stab_err     = 0;
  bit            pend         = 1'b0;
  logic [AW-1:0] pend_addr    = '0;

  // Memory responder plus monitor, all at the falling edge.
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        if (!(mem_we_o || mem_rd_o) || mem_addr_o !== pend_addr) stab_err++;
      end
      case (ack_mode)
        0: mem_ack_i = 1'b1;
        1: begin
          if (mem_we_o || mem_rd_o) begin
            if (!armed) begin
              dly   = $urandom_range(0, 5);
              armed = 1'b1;
            end
            if (dly == 0) begin
              mem_ack_i = 1'b1;
              armed     = 1'b0;
            end else begin
              mem_ack_i = 1'b0;
              dly--;
            end
          end else begin
            mem_ack_i = 1'b0;
          end
        end
        default: mem_ack_i = 1'b0;
      endcase
      mem_data_i = mem_rd_o ? (rd_base + 32'(mem_addr_o[4:2])) : 32'h0;
      if ((mem_we_o || mem_rd_o) && mem_ack_i) begin
        obs_addr_q.push_back(mem_addr_o);
        obs_data_q.push_back(mem_we_o ? mem_data_o : mem_data_i);
        obs_we_q.push_back(mem_we_o);
      end
      pend      = (mem_we_o || mem_rd_o) && !mem_ack_i;
      pend_addr = mem_addr_o;
      if (ctrl_ack_o) begin
        ack_cnt++;
        last_ack_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (ctrl_ack_o) seen = 1'b1;
    end
  endtask

  task automatic clear_obs();
    obs_addr_q.delete();
    obs_data_q.delete();
    obs_we_q.delete();
    ack_cnt  = 0;
    stab_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctrl_addr_i = '0;
    ctrl_data_i = '0;
    ctrl_we_i = 1'b0;
    ctrl_rd_i = 1'b0;
    #1;
    total++;
    if (ctrl_ack_o !== 1'b0 || mem_we_o !== 1'b0 || mem_rd_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes ack=%b we=%b rd=%b want 0", ctrl_ack_o, mem_we_o, mem_rd_o);
    end
    total++;
    if (mem_addr_o !== '0 || mem_data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem_bus addr=%h data=%h want 0", mem_addr_o, mem_data_o);
    end
    total++;
    if (ctrl_data_o !== 256'h0 || err_o !== 1'b0 || state_value !== 16'h0) begin
      bad++;
      $display("FAIL reset_regs data=%h err=%b state=%0d want 0", ctrl_data_o, err_o, state_value);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (state_value !== 16'h0 || ctrl_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release state=%0d ack=%b want 0/0", state_value, ctrl_ack_o);
    end
  endtask

  task automatic test_write();
    bit seen;
    int start;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic w;
    ack_mode = 0;
    clear_obs();
    ctrl_addr_i = 29'h100;
    for (int k = 0; k < 8; k++) ctrl_data_i[32*k +: 32] = 32'hA0A0_0000 + 32'(k);
    ctrl_we_i = 1'b1;
    start = cyc;
    wait_ack(40, seen);
    ctrl_we_i = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wr_ack_seen got=0 want=1");
    end
    total++;
    if (last_ack_cyc - start != 9) begin
      bad++;
      $display("FAIL wr_latency got=%0d want=9", last_ack_cyc - start);
    end
    total++;
    if (ctrl_data_o !== 256'h0) begin
      bad++;
      $display("FAIL wr_rdata_untouched got=%h want=0", ctrl_data_o);
    end
    repeat (4) tick();
    total++;
    if (ack_cnt != 1) begin
      bad++;
      $display("FAIL wr_ack_count got=%0d want=1", ack_cnt);
    end
    total++;
    if (obs_addr_q.size() != 8) begin
      bad++;
      $display("FAIL wr_beat_count got=%0d want=8", obs_addr_q.size());
    end
    for (int k = 0; k < 8 && obs_addr_q.size() > 0; k++) begin
      a = obs_addr_q.pop_front();
      d = obs_data_q.pop_front();
      w = obs_we_q.pop_front();
      total++;
      if (a !== 29'(32'h100 + 32'(4 * k)) || d !== 32'hA0A0_0000 + 32'(k) || w !== 1'b1) begin
        bad++;
        $display("FAIL wr_beat%0d addr=%h data=%h we=%b want %h %h 1", k, a, d, w,
                 32'h100 + 32'(4 * k), 32'hA0A0_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_read();
    bit seen;
    int start;
    logic [255:0] exp_line;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic w;
    ack_mode = 0;
    rd_base = 32'hB000_0000;
    clear_obs();
    for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = 32'hB000_0000 + 32'(k);
    ctrl_addr_i = 29'h100;
    ctrl_rd_i = 1'b1;
    start = cyc;
    wait_ack(40, seen);
    total++;
    if (!seen || ctrl_data_o !== exp_line) begin
      bad++;
      $display("FAIL rd_line_at_ack seen=%b got=%h want=%h", seen, ctrl_data_o, exp_line);
    end
    ctrl_rd_i = 1'b0;
    total++;
    if (last_ack_cyc - start != 9) begin
      bad++;
      $display("FAIL rd_latency got=%0d want=9", last_ack_cyc - start);
    end
    repeat (4) tick();
    total++;
    if (ctrl_data_o !== exp_line || ack_cnt != 1) begin
      bad++;
      $display("FAIL rd_hold data=%h acks=%0d want %h 1", ctrl_data_o, ack_cnt, exp_line);
    end
    total++;
    if (obs_addr_q.size() != 8) begin
      bad++;
      $display("FAIL rd_beat_count got=%0d want=8", obs_addr_q.size());
    end
    for (int k = 0; k < 8 && obs_addr_q.size() > 0; k++) begin
      a = obs_addr_q.pop_front();
      d = obs_data_q.pop_front();
      w = obs_we_q.pop_front();
      total++;
      if (a !== 29'(32'h100 + 32'(4 * k)) || w !== 1'b0) begin
        bad++;
        $display("FAIL rd_beat%0d addr=%h we=%b data=%h want %h 0", k, a, w, d, 32'h100 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen1, seen2;
    int ack1;
    logic [255:0] exp_line;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic w;
    ack_mode = 0;
    rd_base = 32'hC000_0000;
    clear_obs();
    for (int k = 0; k < 8; k++) begin
      ctrl_data_i[32*k +: 32] = 32'h5500_0000 + 32'(k);
      exp_line[32*k +: 32] = 32'hC000_0000 + 32'(k);
    end
    ctrl_addr_i = 29'h200;
    ctrl_we_i = 1'b1;
    wait_ack(40, seen1);
    ack1 = last_ack_cyc;
    // write-back done: drop we and raise rd in the ack cycle
    ctrl_we_i = 1'b0;
    ctrl_rd_i = 1'b1;
    ctrl_addr_i = 29'h400;
    wait_ack(40, seen2);
    ctrl_rd_i = 1'b0;
    total++;
    if (!seen1 || !seen2) begin
      bad++;
      $display("FAIL b2b_acks_seen got=%b%b want=11", seen1, seen2);
    end
    total++;
    if (last_ack_cyc - ack1 != 10) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=10", last_ack_cyc - ack1);
    end
    total++;
    if (ctrl_data_o !== exp_line) begin
      bad++;
      $display("FAIL b2b_rdata got=%h want=%h", ctrl_data_o, exp_line);
    end
    repeat (4) tick();
    total++;
    if (ack_cnt != 2 || obs_addr_q.size() != 16) begin
      bad++;
      $display("FAIL b2b_counts acks=%0d beats=%0d want 2 16", ack_cnt, obs_addr_q.size());
    end
    for (int k = 0; k < 16 && obs_addr_q.size() > 0; k++) begin
      a = obs_addr_q.pop_front();
      d = obs_data_q.pop_front();
      w = obs_we_q.pop_front();
      total++;
      if (k < 8) begin
        if (a !== 29'(32'h200 + 32'(4 * k)) || d !== 32'h5500_0000 + 32'(k) || w !== 1'b1) begin
          bad++;
          $display("FAIL b2b_wbeat%0d addr=%h data=%h we=%b", k, a, d, w);
        end
      end else begin
        if (a !== 29'(32'h400 + 32'(4 * (k - 8))) || w !== 1'b0) begin
          bad++;
          $display("FAIL b2b_rbeat%0d addr=%h we=%b want %h 0", k - 8, a, w, 32'h400 + 32'(4 * (k - 8)));
        end
      end
    end
  endtask

  task automatic test_random_delay();
    bit seen;
    logic [255:0] exp_line;
    logic [AW-1:0] a;
    ack_mode = 1;
    armed = 1'b0;
    rd_base = 32'hD000_0000;
    clear_obs();
    for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = 32'hD000_0000 + 32'(k);
    ctrl_addr_i = 29'h1F;
    ctrl_rd_i = 1'b1;
    wait_ack(200, seen);
    ctrl_rd_i = 1'b0;
    total++;
    if (!seen || ctrl_data_o !== exp_line) begin
      bad++;
      $display("FAIL rnd_line seen=%b got=%h want=%h", seen, ctrl_data_o, exp_line);
    end
    total++;
    if (stab_err != 0) begin
      bad++;
      $display("FAIL rnd_stable got=%0d want=0", stab_err);
    end
    total++;
    if (obs_addr_q.size() != 8) begin
      bad++;
      $display("FAIL rnd_beat_count got=%0d want=8", obs_addr_q.size());
    end
    for (int k = 0; k < 8 && obs_addr_q.size() > 0; k++) begin
      a = obs_addr_q.pop_front();
      void'(obs_data_q.pop_front());
      void'(obs_we_q.pop_front());
      total++;
      if (a !== 29'(4 * k)) begin
        bad++;
        $display("FAIL rnd_beat%0d addr=%h want=%h", k, a, 4 * k);
      end
    end
    ack_mode = 0;
    tick();
  endtask

  task automatic test_both_req();
    bit seen;
    logic [255:0] prev_line;
    logic [AW-1:0] a;
    logic w;
    int wr_ok;
    ack_mode = 0;
    clear_obs();
    prev_line = 256'h0;
    for (int k = 0; k < 8; k++) begin
      ctrl_data_i[32*k +: 32] = 32'h1234_0000 + 32'(k);
      prev_line[32*k +: 32] = 32'hD000_0000 + 32'(k);
    end
    ctrl_addr_i = 29'h40;
    ctrl_we_i = 1'b1;
    ctrl_rd_i = 1'b1;
    wait_ack(40, seen);
    ctrl_we_i = 1'b0;
    ctrl_rd_i = 1'b0;
    total++;
    if (!seen || err_o !== 1'b1) begin
      bad++;
      $display("FAIL both_err seen=%b err=%b want 1 1", seen, err_o);
    end
    repeat (12) tick();
    total++;
    if (ack_cnt != 1 || obs_addr_q.size() != 8) begin
      bad++;
      $display("FAIL both_single acks=%0d beats=%0d want 1 8", ack_cnt, obs_addr_q.size());
    end
    wr_ok = 1;
    for (int k = 0; k < 8 && obs_addr_q.size() > 0; k++) begin
      a = obs_addr_q.pop_front();
      void'(obs_data_q.pop_front());
      w = obs_we_q.pop_front();
      if (a !== 29'(32'h40 + 32'(4 * k)) || w !== 1'b1) wr_ok = 0;
    end
    total++;
    if (wr_ok != 1) begin
      bad++;
      $display("FAIL both_write_served got=0 want=1");
    end
    total++;
    if (ctrl_data_o !== prev_line || err_o !== 1'b1 || state_value !== 16'h0) begin
      bad++;
      $display("FAIL both_after data=%h err=%b state=%0d", ctrl_data_o, err_o, state_value);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int start;
    logic [255:0] exp_line;
    ack_mode = 0;
    rd_base = 32'hE000_0000;
    clear_obs();
    ctrl_addr_i = 29'h300;
    ctrl_rd_i = 1'b1;
    for (int i = 0; i < 20 && obs_addr_q.size() < 5; i++) tick();
    total++;
    if (obs_addr_q.size() != 5 || state_value !== 16'd2) begin
      bad++;
      $display("FAIL mid_reach_beat4 beats=%0d state=%0d want 5 2", obs_addr_q.size(), state_value);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_rd_o !== 1'b0 || mem_addr_o !== '0 || ctrl_ack_o !== 1'b0 || state_value !== 16'h0) begin
      bad++;
      $display("FAIL mid_outputs rd=%b addr=%h ack=%b state=%0d want 0", mem_rd_o, mem_addr_o, ctrl_ack_o, state_value);
    end
    total++;
    if (ctrl_data_o !== 256'h0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_clear data=%h err=%b want 0", ctrl_data_o, err_o);
    end
    ctrl_rd_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if (ack_cnt != 0) begin
      bad++;
      $display("FAIL mid_no_ack got=%0d want=0", ack_cnt);
    end
    rd_base = 32'hF000_0000;
    for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = 32'hF000_0000 + 32'(k);
    ctrl_rd_i = 1'b1;
    start = cyc;
    wait_ack(40, seen);
    ctrl_rd_i = 1'b0;
    total++;
    if (!seen || ctrl_data_o !== exp_line || last_ack_cyc - start != 9) begin
      bad++;
      $display("FAIL mid_recover seen=%b lat=%0d got=%h want=%h", seen, last_ack_cyc - start, ctrl_data_o, exp_line);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit seen;
    int start;
    ack_mode = 2;
    clear_obs();
    ctrl_addr_i = 29'h500;
    ctrl_we_i = 1'b1;
    start = cyc;
    wait_ack(60, seen);
    ctrl_we_i = 1'b0;
`ifdef DDR3_LINE_TIMEOUT_EN
    total++;
    if (!seen || err_o !== 1'b1) begin
      bad++;
      $display("FAIL to_ack seen=%b err=%b want 1 1", seen, err_o);
    end
    // beat starts one cycle after accept; ack 17 cycles later
    total++;
    if (last_ack_cyc - start != 18) begin
      bad++;
      $display("FAIL to_latency got=%0d want=18", last_ack_cyc - start);
    end
    total++;
    if (obs_addr_q.size() != 0) begin
      bad++;
      $display("FAIL to_no_beats got=%0d want=0", obs_addr_q.size());
    end
`else
    total++;
    if (seen) begin
      bad++;
      $display("FAIL to_no_ack got=1 want=0");
    end
    total++;
    if (state_value !== 16'd1 || mem_we_o !== 1'b1 || mem_addr_o !== 29'h500) begin
      bad++;
      $display("FAIL to_waiting state=%0d we=%b addr=%h want 1 1 500", state_value, mem_we_o, mem_addr_o);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (state_value !== 16'h0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL to_recover state=%0d err=%b want 0 0", state_value, err_o);
    end
`endif
    ack_mode = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim_time_exceeded");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_random_delay();
    test_both_req();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
